// File: rtl/timer_display_scanner_if.sv
// Conversion handshake between a seconds source and the display scanner:
// the source offers a seconds value with a load strobe and a mode select,
// the scanner answers with busy, a done pulse and the saturation flag.
interface timer_display_scanner_if #(
  parameter int TIMER_W = 11
) ();

  logic [TIMER_W-1:0] timer;
  logic               load;
  logic               mode;
  logic               busy;
  logic               done;
  logic               sat;

  modport master (
    output timer, load, mode,
    input  busy, done, sat
  );

  modport slave (
    input  timer, load, mode,
    output busy, done, sat
  );

endinterface

// File: rtl/timer_display_scanner.sv
// Seconds-to-display converter for the parking system's 4-digit common-anode
// display. A seconds count is captured on load and split into four BCD digits
// by a subtract-and-count engine (one subtraction per clock, no dividers),
// either as MM:SS or as a plain decimal number. The committed digits are then
// shown by multiplexed anode scanning with optional leading-zero blanking,
// colon dot in MM:SS mode and whole-display blinking.
module timer_display_scanner #(
  parameter int TIMER_W     = 11,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  timer_display_scanner_if.slave bus,
  input  logic                   blank_lead,
  input  logic                   blink_en,
  output logic [6:0]             seg,
  output logic [3:0]             an,
  output logic                   dp
);

  // Threshold compares need room for 10000, so never go narrower than 14 bits.
  localparam int CW  = (TIMER_W > 14) ? TIMER_W : 14;
  localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST   = BCW'(BLINK_DIV - 1);

  localparam logic [CW-1:0] SAT_MMSS = CW'(6000);
  localparam logic [CW-1:0] SAT_DEC  = CW'(10000);

  typedef enum logic [2:0] {
    IDLE,
    MIN,
    MT,
    ST,
    D3,
    D2,
    D1,
    COMMIT
  } state_t;

  // Conversion engine state and working registers
  state_t          state, state_n;
  logic [CW-1:0]   rem, rem_n;
  logic [6:0]      mins, mins_n;
  logic [3:0]      w3, w3_n;
  logic [3:0]      w2, w2_n;
  logic [3:0]      w1, w1_n;
  logic [3:0]      w0, w0_n;
  logic            sat_w, sat_w_n;
  logic            mode_w, mode_w_n;

  // Committed results seen by the display side
  logic [15:0]     disp, disp_n;
  logic            disp_mode, disp_mode_n;
  logic            sat_q, sat_q_n;
  logic            busy_q, busy_q_n;
  logic            done_q, done_q_n;

  // Scanning and blinking
  logic [RCW-1:0]  rcnt;
  logic [1:0]      scan_idx;
  logic [BCW-1:0]  bcnt;
  logic            phase;

  logic [1:0]      idx_nx;
  logic [3:0]      digit_nx;
  logic            blank_nx;
  logic            blank3, blank2, blank1;
  logic [6:0]      seg_nx;
  logic [3:0]      an_nx;
  logic            dp_nx;

  logic [CW-1:0]   timer_ext;

  assign timer_ext = CW'(bus.timer);

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sat  = sat_q;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // Register the conversion FSM, its datapath and the committed results
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      mins      <= '0;
      w3        <= '0;
      w2        <= '0;
      w1        <= '0;
      w0        <= '0;
      sat_w     <= 1'b0;
      mode_w    <= 1'b0;
      disp      <= '0;
      disp_mode <= 1'b0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      mins      <= mins_n;
      w3        <= w3_n;
      w2        <= w2_n;
      w1        <= w1_n;
      w0        <= w0_n;
      sat_w     <= sat_w_n;
      mode_w    <= mode_w_n;
      disp      <= disp_n;
      disp_mode <= disp_mode_n;
      sat_q     <= sat_q_n;
      busy_q    <= busy_q_n;
      done_q    <= done_q_n;
    end
  end

  // One subtract-or-advance step per cycle; digits appear on the display only at COMMIT
  always_comb begin
    state_n     = state;
    rem_n       = rem;
    mins_n      = mins;
    w3_n        = w3;
    w2_n        = w2;
    w1_n        = w1;
    w0_n        = w0;
    sat_w_n     = sat_w;
    mode_w_n    = mode_w;
    disp_n      = disp;
    disp_mode_n = disp_mode;
    sat_q_n     = sat_q;
    busy_q_n    = busy_q;
    done_q_n    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.load) begin
          rem_n    = timer_ext;
          mode_w_n = bus.mode;
          mins_n   = '0;
          w3_n     = '0;
          w2_n     = '0;
          w1_n     = '0;
          w0_n     = '0;
          busy_q_n = 1'b1;
          if ((!bus.mode && timer_ext >= SAT_MMSS) ||
              ( bus.mode && timer_ext >= SAT_DEC)) begin
            sat_w_n = 1'b1;
            state_n = COMMIT;
          end else begin
            sat_w_n = 1'b0;
            state_n = bus.mode ? D3 : MIN;
          end
        end
      end

      MIN: begin
        if (rem >= CW'(60)) begin
          rem_n  = rem - CW'(60);
          mins_n = mins + 7'd1;
        end else begin
          state_n = MT;
        end
      end

      MT: begin
        if (mins >= 7'd10) begin
          mins_n = mins - 7'd10;
          w3_n   = w3 + 4'd1;
        end else begin
          w2_n    = mins[3:0];
          state_n = ST;
        end
      end

      ST: begin
        if (rem >= CW'(10)) begin
          rem_n = rem - CW'(10);
          w1_n  = w1 + 4'd1;
        end else begin
          w0_n    = rem[3:0];
          state_n = COMMIT;
        end
      end

      D3: begin
        if (rem >= CW'(1000)) begin
          rem_n = rem - CW'(1000);
          w3_n  = w3 + 4'd1;
        end else begin
          state_n = D2;
        end
      end

      D2: begin
        if (rem >= CW'(100)) begin
          rem_n = rem - CW'(100);
          w2_n  = w2 + 4'd1;
        end else begin
          state_n = D1;
        end
      end

      D1: begin
        if (rem >= CW'(10)) begin
          rem_n = rem - CW'(10);
          w1_n  = w1 + 4'd1;
        end else begin
          w0_n    = rem[3:0];
          state_n = COMMIT;
        end
      end

      COMMIT: begin
        if (sat_w) begin
          disp_n = mode_w ? 16'h9999 : 16'h9959;
        end else begin
          disp_n = {w3, w2, w1, w0};
        end
        sat_q_n     = sat_w;
        disp_mode_n = mode_w;
        done_q_n    = 1'b1;
        busy_q_n    = 1'b0;
        state_n     = IDLE;
      end

      default: begin
        state_n  = IDLE;
        busy_q_n = 1'b0;
      end
    endcase
  end

  // Work out what the next scan slot should show, including blanking and blink
  always_comb begin
    idx_nx   = scan_idx + 2'd1;
    blank3   = blank_lead && (disp[15:12] == 4'd0);
    blank2   = blank3 && disp_mode && (disp[11:8] == 4'd0);
    blank1   = blank2 && (disp[7:4] == 4'd0);
    digit_nx = disp[3:0];
    blank_nx = 1'b0;

    case (idx_nx)
      2'd0: begin
        digit_nx = disp[3:0];
        blank_nx = 1'b0;
      end
      2'd1: begin
        digit_nx = disp[7:4];
        blank_nx = blank1;
      end
      2'd2: begin
        digit_nx = disp[11:8];
        blank_nx = blank2;
      end
      default: begin
        digit_nx = disp[15:12];
        blank_nx = blank3;
      end
    endcase

    seg_nx = blank_nx ? 7'b1111111 : seg_code(digit_nx);
    an_nx  = (blink_en && !phase) ? 4'b1111 : ~(4'b0001 << idx_nx);
    dp_nx  = !(!disp_mode && (idx_nx == 2'd2));
  end

  // Refresh counter steps the scan index and loads the display outputs on wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt     <= '0;
      scan_idx <= 2'd3;
      seg      <= 7'b1111111;
      an       <= 4'b1111;
      dp       <= 1'b1;
    end else if (rcnt == REFRESH_LAST) begin
      rcnt     <= '0;
      scan_idx <= idx_nx;
      seg      <= seg_nx;
      an       <= an_nx;
      dp       <= dp_nx;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Blink phase toggles every BLINK_DIV cycles and parks at "on" while disabled
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BLINK_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_display_scanner.sv
// Bench for timer_display_scanner: loads go through a scoreboard queue holding
// the expected digits, saturation flag and latency; each done pulse pops one
// entry, and the committed digits are then read back off the scanned display.
module tb_timer_display_scanner;

  localparam int TW = 14;
  localparam int RD = 4;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       blank_lead;
  logic       blink_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tick   = 0;

  typedef struct {
    logic [15:0] dig;
    logic        sat;
    logic        mode;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];

  timer_display_scanner_if #(.TIMER_W(TW)) tb_if ();

  timer_display_scanner #(
    .TIMER_W(TW),
    .REFRESH_DIV(RD),
    .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(tb_if),
    .blank_lead(blank_lead),
    .blink_en(blink_en),
    .seg(seg),
    .an(an),
    .dp(dp)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edges since reset release, matching the scan timing reference
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Negedge count used to measure conversion latency
  always @(negedge clk) tick <= tick + 1;

  // Hard stop if something stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] segOf(input logic [3:0] d, input bit blank);
    logic [6:0] c;
    if (blank) return 7'b1111111;
    case (d)
      4'd0: c = 7'b1000000;
      4'd1: c = 7'b1111001;
      4'd2: c = 7'b0100100;
      4'd3: c = 7'b0110000;
      4'd4: c = 7'b0011001;
      4'd5: c = 7'b0010010;
      4'd6: c = 7'b0000010;
      4'd7: c = 7'b1111000;
      4'd8: c = 7'b0000000;
      4'd9: c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  function automatic exp_t modelOf(input int t, input bit m);
    exp_t e;
    int mins, s;
    e.mode = m;
    e.t0   = 0;
    if (!m && t >= 6000) begin
      e.dig = 16'h9959; e.sat = 1'b1; e.lat = 1;
    end else if (m && t >= 10000) begin
      e.dig = 16'h9999; e.sat = 1'b1; e.lat = 1;
    end else if (!m) begin
      mins  = t / 60;
      s     = t % 60;
      e.dig = {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
      e.sat = 1'b0;
      e.lat = (mins + 1) + (mins / 10 + 1) + (s / 10 + 1) + 1;
    end else begin
      e.dig = {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
      e.sat = 1'b0;
      e.lat = (t / 1000 + 1) + ((t % 1000) / 100 + 1) + ((t % 100) / 10 + 1) + 1;
    end
    return e;
  endfunction

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Drive one load strobe; accepted loads get a scoreboard entry
  task automatic applyStimulus(input int t, input bit m, input bit accepted);
    exp_t e;
    @(negedge clk);
    tb_if.timer = TW'(t);
    tb_if.mode  = m;
    tb_if.load  = 1'b1;
    if (accepted) begin
      e    = modelOf(t, m);
      e.t0 = tick;
      sb.push_back(e);
    end
    @(negedge clk);
    tb_if.load = 1'b0;
    checkOutput("busy_after_load", tb_if.busy, 1);
  endtask

  // Wait for done, pop the scoreboard and compare latency and flags
  task automatic collectDone(output logic [15:0] dig, output bit m);
    bit   got = 0;
    exp_t e;
    dig = '0;
    m   = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (tb_if.done) begin
        got = 1;
        if (sb.size() == 0) begin
          checkOutput("done_without_load", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", tick - e.t0 - 1, e.lat);
          checkOutput("sat", tb_if.sat, e.sat);
          checkOutput("busy_at_done", tb_if.busy, 0);
          dig = e.dig;
          m   = e.mode;
        end
      end
    end
    if (!got) checkOutput("done_timeout", 0, 1);
    @(negedge clk);
    checkOutput("done_pulse_width", tb_if.done, 0);
  endtask

  // Observe four consecutive scan slots and compare each against the digits
  task automatic checkDisplay(input logic [15:0] dig, input bit m, input bit bl);
    bit         b3, b2, b1, blank;
    int         idx;
    logic [3:0] d;
    logic [3:0] ea;
    logic [6:0] es;
    logic       edp;
    b3 = bl && (dig[15:12] == 4'd0);
    b2 = b3 && m && (dig[11:8] == 4'd0);
    b1 = b2 && (dig[7:4] == 4'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      while ((cyc % RD) != 0 || cyc < RD) @(negedge clk);
      idx   = (cyc / RD + 3) % 4;
      d     = dig[idx*4 +: 4];
      blank = (idx == 3) ? b3 : (idx == 2) ? b2 : (idx == 1) ? b1 : 1'b0;
      ea    = ~(4'b0001 << idx);
      es    = segOf(d, blank);
      edp   = (!m && idx == 2) ? 1'b0 : 1'b1;
      checkOutput($sformatf("an_slot%0d", idx), an, ea);
      checkOutput($sformatf("seg_slot%0d", idx), seg, es);
      checkOutput($sformatf("dp_slot%0d", idx), dp, edp);
    end
  endtask

  task automatic convertAndShow(input int t, input bit m, input bit bl);
    logic [15:0] dig;
    bit          dm;
    blank_lead = bl;
    applyStimulus(t, m, 1);
    collectDone(dig, dm);
    checkDisplay(dig, dm, bl);
  endtask

  initial begin
    logic [15:0] dig;
    bit          dm;
    int          e0, n, idx;
    logic [3:0]  ea;

    reset       = 1'b1;
    blank_lead  = 1'b0;
    blink_en    = 1'b0;
    tb_if.load  = 1'b0;
    tb_if.timer = '0;
    tb_if.mode  = 1'b0;

    // Reset state and first scan
    repeat (3) @(negedge clk);
    checkOutput("rst_seg", seg, 7'b1111111);
    checkOutput("rst_an", an, 4'b1111);
    checkOutput("rst_dp", dp, 1);
    checkOutput("rst_busy", tb_if.busy, 0);
    checkOutput("rst_done", tb_if.done, 0);
    checkOutput("rst_sat", tb_if.sat, 0);
    reset = 1'b0;
    waitCyc(3);
    checkOutput("an_before_first_slot", an, 4'b1111);
    checkDisplay(16'h0000, 0, 0);

    // MM:SS with blanking, decimal, blanking boundaries
    convertAndShow(125, 0, 1);
    convertAndShow(2047, 1, 0);
    convertAndShow(7, 1, 1);
    convertAndShow(1005, 1, 1);
    convertAndShow(0, 0, 1);

    // Worst-case latency and saturation boundaries
    convertAndShow(5999, 0, 0);
    convertAndShow(6000, 0, 0);
    convertAndShow(9999, 1, 0);
    convertAndShow(10000, 1, 0);
    convertAndShow(12000, 1, 0);

    // Load while busy is ignored
    blank_lead = 1'b0;
    applyStimulus(2047, 0, 1);
    applyStimulus(5, 0, 0);
    collectDone(dig, dm);
    checkDisplay(dig, dm, 0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (tb_if.done) n++;
    end
    checkOutput("no_extra_done", n, 0);
    checkOutput("sat_cleared", tb_if.sat, 0);

    // Reset wins over a simultaneous load
    @(negedge clk);
    reset       = 1'b1;
    tb_if.load  = 1'b1;
    tb_if.timer = TW'(100);
    @(negedge clk);
    reset      = 1'b0;
    tb_if.load = 1'b0;
    checkOutput("busy_reset_vs_load", tb_if.busy, 0);

    // Reset mid-conversion discards the partial result
    applyStimulus(2047, 0, 1);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    checkOutput("busy_after_midreset", tb_if.busy, 0);
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (tb_if.done) n++;
    end
    checkOutput("no_done_after_midreset", n, 0);
    checkDisplay(16'h0000, 0, 0);

    // Blink: display dark during the off phases, normal scan once disabled
    @(negedge clk);
    blink_en = 1'b1;
    e0 = cyc;
    waitCyc(e0 + 24);
    checkOutput("blink_off_24", an, 4'b1111);
    waitCyc(e0 + 28);
    checkOutput("blink_off_28", an, 4'b1111);
    waitCyc(e0 + 40);
    idx = (cyc / RD + 3) % 4;
    ea  = ~(4'b0001 << idx);
    checkOutput("blink_on_40", an, ea);
    waitCyc(e0 + 56);
    checkOutput("blink_off_56", an, 4'b1111);
    waitCyc(e0 + 60);
    blink_en = 1'b0;
    waitCyc(e0 + 68);
    idx = (cyc / RD + 3) % 4;
    ea  = ~(4'b0001 << idx);
    checkOutput("blink_disabled", an, ea);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_display_scanner.md
# timer_display_scanner

Sequential successor to the combinational seconds-to-7-seg converter in the parking system. Captures a seconds count on `load` and converts it to four BCD digits with an iterative subtract-and-count engine, so no dividers are inferred. Supports MM:SS or plain decimal mode, leading-zero blanking, blink and saturation. Drives the 4-digit common-anode display directly through multiplexed anode scanning.

## Interface
- `TIMER_W`, 11: timer width in bits; must be at least 4.
- `REFRESH_DIV`, 100000: clk cycles per digit scan slot.
- `BLINK_DIV`, 50000000: clk cycles per blink half-period.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: reset, synchronous, active-high.
- `timer` in TIMER_W: seconds value; sampled only on an accepted load.
- `load` in 1: start a conversion; accepted only when `busy`=0.
- `mode` in 1: sampled with `load`. 0 = MM:SS, 1 = decimal 0–9999.
- `blank_lead` in 1: live input; enables leading-zero blanking.
- `blink_en` in 1: live input; enables flashing the whole display.
- `seg` out 7: active-low segments, bit order {g,f,e,d,c,b,a}.
- `an` out 4: active-low anodes; `an[0]` is the rightmost digit.
- `dp` out 1: active-low decimal point.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when the new digits are committed.
- `sat` out 1: the last committed value was saturated.

## Operation
- **FSM states:** IDLE, MIN, MT, ST, D3, D2, D1, COMMIT.
- **One step per cycle.** Each cycle in a divide state, if remainder ≥ divisor: subtract the divisor and increment the digit counter. Otherwise advance to the next state.
- **Accepted load (IDLE, `load`=1):**
  - Capture `timer` into the remainder and `mode` into the mode register; clear the working digits; set `busy`.
  - If `mode`=0 and timer ≥ 6000, or `mode`=1 and timer ≥ 10000: set the saturation flag and go straight to COMMIT.
  - Threshold compares are done at max(TIMER_W, 14) bits.
- **Mode 0 path:**
  - MIN: divisor 60, builds the minutes count (7 bits).
  - MT: divisor 10 applied to minutes; produces d3 (tens) and d2 (ones).
  - ST: divisor 10 applied to the seconds remainder; produces d1 and d0.
- **Mode 1 path:**
  - D3 uses divisor 1000, D2 uses 100, D1 uses 10.
  - The final remainder is d0.
- **COMMIT:**
  - Copy the working digits to the display digits; a saturated value commits as 9959 in mode 0 and 9999 in mode 1.
  - Update `sat` and the display mode register.
  - Pulse `done`, clear `busy`, return to IDLE.
- `load` while `busy`=1 is ignored; there is no queueing.
- **Scanning:**
  - The refresh counter runs 0..REFRESH_DIV-1. On wrap, the scan index advances 0→1→2→3→0.
  - On the same edge, `an`, `seg` and `dp` are updated for the new index.
- **Segment codes (0–9):** 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Blank = 1111111.
- **Blanking (`blank_lead`=1):**
  - Mode 0: d3 is blank if zero.
  - Mode 1: d3, d2, d1 are blanked left-to-right while zero.
  - d0 is never blanked.
- **`dp`:** 0 (lit) only when mode 0 and scan index = 2 (colon position); otherwise 1.
- **Blink:**
  - The blink counter toggles the phase every BLINK_DIV cycles.
  - When `blink_en`=1 and the phase is off, `an`=1111.
  - While `blink_en`=0, the counter is held at zero with phase on.

## Timing
- **Reset values:**
  - `seg`=1111111, `an`=1111, `dp`=1, `busy`=0, `done`=0, `sat`=0.
  - Display digits = 0, scan index = 3, counters = 0, phase on, FSM = IDLE.
- The first lit digit is index 0, appearing at edge REFRESH_DIV after reset release.
- **Conversion latency:** `done` is high in the cycle following edge L+N, where L is the load edge and N is the sum of (subtractions+1) over the divide states, plus 1 for COMMIT.
  - Saturated load: N=1.
  - Worst case: mode 0 N≤117, mode 1 N≤31.
- `busy` rises at L and falls at L+N. The display digits change only at L+N; scanning continues uninterrupted throughout.
- **Reset precedence:** reset at any cycle (including mid-conversion) returns all state to reset values; the partial result is discarded. Reset wins over a simultaneous `load`.
- **Live vs. held inputs:** `blank_lead` and `blink_en` take effect at the next scan update edge. `mode` affects the display only at COMMIT.

## Test plan
Use REFRESH_DIV=4 and BLINK_DIV=16 unless stated.
1. **Reset scan.** Reset, then release → all outputs at reset values; `an`=1110 and `seg`=1000000 at edge 4; `an` cycles 1101, 1011, 0111 every 4 cycles.
2. **MM:SS with blanking.** Mode 0, timer=125, `blank_lead`=1 → `done` 6 cycles after load; digits 0,2,0,5; digit 3 shows 1111111; `dp`=0 only while `an`=1011.
3. **Decimal mode.** Mode 1, timer=2047 → `done` 10 cycles after load; digits 2,0,4,7; `sat`=0.
4. **Saturation.** TIMER_W=14:
   - Mode 0, timer=6000 → `done` 1 cycle after load; digits 9,9,5,9; `sat`=1.
   - Mode 1, timer=12000 → digits 9999.
5. **Busy and reset.** Load 2047 (mode 0), then pulse `load` with 5 while `busy` → 34:07 commits at N=41 and the 5 is ignored. Assert `reset` at cycle 20 of a fresh conversion → no `done`; digits return to 0.
6. **Blink.** `blink_en`=1 → `an`=1111 during cycles 16–31 and 48–63 after enable; `blink_en`=0 → normal scan resumes with phase on.
